// File: rtl/pc_4b_if.sv
// pc_4b_if: fetch-side bus of the 4-bit program counter stage.
//
// Signals:
//   ready      - downstream fetch accepts pc this cycle
//   jump       - absolute redirect request, target in jump_addr
//   jump_addr  - absolute redirect target
//   branch     - relative redirect request, offset in branch_off
//   branch_off - two's-complement offset added to the current pc
//   halt       - request to stop issuing
//   resume     - request to leave HALT
//   pc         - current program counter
//   pc_valid   - pc is a valid fetch address
//   wrap       - one-cycle pulse after a sequential all-ones -> 0 increment
//   state      - control FSM state: 00 INIT, 01 RUN, 10 STALL, 11 HALT
//
// Modports:
//   master - the pc stage (drives pc/pc_valid/wrap/state)
//   slave  - the fetch/control side (drives requests and ready)
interface pc_4b_if #(
  parameter int WIDTH = 4
);
  logic             ready;
  logic             jump;
  logic [WIDTH-1:0] jump_addr;
  logic             branch;
  logic [WIDTH-1:0] branch_off;
  logic             halt;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             wrap;
  logic [1:0]       state;

  modport master (
    input  ready, jump, jump_addr, branch, branch_off, halt, resume,
    output pc, pc_valid, wrap, state
  );

  modport slave (
    output ready, jump, jump_addr, branch, branch_off, halt, resume,
    input  pc, pc_valid, wrap, state
  );
endinterface

// File: rtl/pc_4b.sv
// pc_4b: program counter stage feeding instruction fetch.
//
// Holds the current pc and presents it with a valid/ready handshake.
// Next pc is sequential (pc+1), relative (pc+branch_off) or absolute
// (jump_addr), all modulo 2^WIDTH with the carry discarded. A small
// INIT/RUN/STALL/HALT FSM controls issuing. Every output is registered.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pc_4b_if master modport (requests in, pc/pc_valid/wrap/state out)
module pc_4b #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  pc_4b_if.master bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             wrap_q, wrap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      wrap_q     <= wrap_d;
    end
  end

  // Redirects are taken regardless of ready: the stalled pc is simply
  // replaced. wrap only ever comes from the sequential increment path.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    wrap_d     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        state_d    = ST_RUN;
        pc_d       = RESET_PC;
        pc_valid_d = 1'b1;
      end
      ST_RUN, ST_STALL: begin
        pc_valid_d = 1'b1;
        if (bus.halt) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
        end else if (bus.jump) begin
          state_d = ST_RUN;
          pc_d    = bus.jump_addr;
        end else if (bus.branch) begin
          state_d = ST_RUN;
          pc_d    = pc_q + bus.branch_off;
        end else if (bus.ready) begin
          state_d = ST_RUN;
          pc_d    = pc_q + ONE;
          wrap_d  = (pc_q == ALL_ONES);
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_HALT: begin
        // halt has priority over resume, so both together keep us here
        if (bus.resume && !bus.halt) begin
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.wrap     = wrap_q;
  assign bus.state    = state_q;

endmodule
